// File: rtl/quad_step_decoder_if.sv
// Encoder-side bundle: raw quadrature channels in, step/direction/error pulses out.
interface quad_step_decoder_if;
  logic enc_a;
  logic enc_b;
  logic en;
  logic down;
  logic err;

  modport master (output enc_a, enc_b, input en, down, err);
  modport slave  (input enc_a, enc_b, output en, down, err);
endinterface

// File: rtl/quad_step_decoder.sv
// Quadrature decoder: 2-flop sync and debounce per channel, Gray decode, detent accumulation.
// Input level to en/err pulse takes DEB_CYCLES+3 edges; no backpressure, pulses are fire-and-forget.
module quad_step_decoder #(
  parameter int DEB_CYCLES      = 50000,
  parameter int STEPS_PER_PULSE = 4
) (
  input logic clk50m,
  input logic rst,
  quad_step_decoder_if.slave bus
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic signed [3:0] ACC_TOP = 4'(STEPS_PER_PULSE);
  localparam logic signed [3:0] ACC_BOT = -ACC_TOP;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Bit 1 is channel A, bit 0 is channel B throughout.
  logic [1:0]        sync1;
  logic [1:0]        s_ab;
  logic [1:0]        f_ab;
  logic [1:0]        p_ab;
  logic [CW-1:0]     deb_cnt [2];
  logic [0:0]        state;
  logic [1:0]        init_cnt;
  logic signed [3:0] acc;
  logic              en_r;
  logic              down_r;
  logic              err_r;

  logic [1:0]        pos_p;
  logic [1:0]        pos_f;
  logic [1:0]        delta;
  logic signed [3:0] acc_step;

  // Gray pair to position 0..3 along the up sequence; position difference mod 4
  // gives +1, -1, or 2 for a double-bit jump.
  always_comb begin
    pos_p    = {p_ab[1], p_ab[1] ^ p_ab[0]};
    pos_f    = {f_ab[1], f_ab[1] ^ f_ab[0]};
    delta    = pos_f - pos_p;
    acc_step = (delta == 2'd1) ? acc + 4'sd1 : acc - 4'sd1;
  end

  always_ff @(posedge clk50m) begin
    if (rst) begin
      sync1      <= '0;
      s_ab       <= '0;
      f_ab       <= '0;
      p_ab       <= '0;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
      state      <= ST_INIT;
      init_cnt   <= '0;
      acc        <= '0;
      en_r       <= 1'b0;
      down_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      sync1 <= {bus.enc_a, bus.enc_b};
      s_ab  <= sync1;
      en_r  <= 1'b0;
      err_r <= 1'b0;

      if (state == ST_INIT) begin
        // Prime filter and history with the resting position so it never decodes as a jump.
        f_ab       <= s_ab;
        p_ab       <= s_ab;
        deb_cnt[0] <= '0;
        deb_cnt[1] <= '0;
        init_cnt   <= init_cnt + 2'd1;
        if (init_cnt == 2'd2) begin
          state <= ST_RUN;
        end
      end else begin
        p_ab <= f_ab;

        for (int i = 0; i < 2; i++) begin
          if (s_ab[i] == f_ab[i]) begin
            deb_cnt[i] <= '0;
          end else if (deb_cnt[i] == CNT_LAST) begin
            f_ab[i]    <= s_ab[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + CW'(1);
          end
        end

        case (delta)
          2'd2: begin
            err_r <= 1'b1;
            acc   <= '0;
          end
          2'd1, 2'd3: begin
            if (acc_step == ACC_TOP) begin
              en_r   <= 1'b1;
              down_r <= 1'b0;
              acc    <= '0;
            end else if (acc_step == ACC_BOT) begin
              en_r   <= 1'b1;
              down_r <= 1'b1;
              acc    <= '0;
            end else begin
              acc <= acc_step;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.en   = en_r;
  assign bus.down = down_r;
  assign bus.err  = err_r;
endmodule

// File: tb/tb_quad_step_decoder.sv
// Randomised and directed bench for quad_step_decoder against a window-based behavioural model.
module tb_quad_step_decoder;
  localparam int DEB = 4;
  localparam int SPP = 4;

  logic clk50m = 1'b0;
  logic rst    = 1'b1;
  logic drv_a  = 1'b0;
  logic drv_b  = 1'b0;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  quad_step_decoder_if bus ();
  assign bus.enc_a = drv_a;
  assign bus.enc_b = drv_b;

  quad_step_decoder #(.DEB_CYCLES(DEB), .STEPS_PER_PULSE(SPP)) dut (
    .clk50m (clk50m),
    .rst    (rst),
    .bus    (bus.slave)
  );

  always #10 clk50m = ~clk50m;

  // Model state: raw input history (index 0 = newest), filtered pair, previous pair.
  logic [1:0] hist [DEB+2];
  logic [1:0] m_f;
  logic [1:0] m_prev;
  int         m_acc;
  int         m_init;
  int         m_d;
  logic       m_stable;
  logic       e_en   = 1'b0;
  logic       e_down = 1'b0;
  logic       e_err  = 1'b0;

  int n_en        = 0;
  int n_en_dn     = 0;
  int n_err       = 0;
  int last_en_cyc = 0;

  function automatic int gpos(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] gpair(input int p);
    case (p)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk50m);
    #5;
  endtask

  task automatic set_enc(input logic a, input logic b, input int hold);
    drv_a = a;
    drv_b = b;
    tick(hold);
  endtask

  task automatic model_edge();
    if (rst) begin
      for (int j = 0; j < DEB + 2; j++) hist[j] = 2'b00;
      m_f = 2'b00; m_prev = 2'b00; m_acc = 0; m_init = 0;
      e_en = 1'b0; e_down = 1'b0; e_err = 1'b0;
    end else begin
      e_en  = 1'b0;
      e_err = 1'b0;
      if (m_init >= 3) begin
        m_d = (gpos(m_f) - gpos(m_prev) + 4) % 4;
        if (m_d == 2) begin
          e_err = 1'b1;
          m_acc = 0;
        end else if (m_d != 0) begin
          m_acc += (m_d == 1) ? 1 : -1;
          if (m_acc == SPP) begin
            e_en = 1'b1; e_down = 1'b0; m_acc = 0;
          end else if (m_acc == -SPP) begin
            e_en = 1'b1; e_down = 1'b1; m_acc = 0;
          end
        end
      end
      if (m_init < 3) begin
        m_f    = hist[1];
        m_prev = hist[1];
        m_init++;
      end else begin
        // A channel flips once its last DEB synchronised samples all disagree with it.
        m_prev = m_f;
        for (int ch = 0; ch < 2; ch++) begin
          m_stable = 1'b1;
          for (int j = 1; j <= DEB; j++) begin
            if (hist[j][ch] == m_f[ch]) m_stable = 1'b0;
          end
          if (m_stable) m_f[ch] = ~m_f[ch];
        end
      end
      for (int j = DEB + 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = {drv_a, drv_b};
    end
  endtask

  initial begin
    int b_en, b_dn, b_err, k, r, p;
    logic [1:0] nxt;

    fork
      forever begin
        @(posedge clk50m);
        cyc++;
        model_edge();
      end
      forever begin
        @(negedge clk50m);
        chk("en", 32'(bus.en), 32'(e_en));
        chk("down", 32'(bus.down), 32'(e_down));
        chk("err", 32'(bus.err), 32'(e_err));
        if (bus.en) begin
          n_en++;
          last_en_cyc = cyc;
          if (bus.down) n_en_dn++;
        end
        if (bus.err) n_err++;
      end
    join_none

    // Reset state
    rst = 1'b1;
    tick(3);
    chk("rst_en", 32'(bus.en), 0);
    chk("rst_down", 32'(bus.down), 0);
    chk("rst_err", 32'(bus.err), 0);
    rst = 1'b0;
    tick(10);

    // Clean up sequence: one pulse, down=0, at edge k+2+DEB of the final change
    b_en = n_en; b_dn = n_en_dn; b_err = n_err;
    set_enc(1'b0, 1'b1, 20);
    set_enc(1'b1, 1'b1, 20);
    set_enc(1'b1, 1'b0, 20);
    k = cyc + 1;
    set_enc(1'b0, 1'b0, 20);
    chk("up_en_count", n_en - b_en, 1);
    chk("up_down_count", n_en_dn - b_dn, 0);
    chk("up_en_edge", last_en_cyc, k + 2 + DEB);
    chk("up_err_count", n_err - b_err, 0);

    // Reverse sequence twice: two down pulses, down stays high
    b_en = n_en; b_dn = n_en_dn; b_err = n_err;
    for (int rep = 0; rep < 2; rep++) begin
      set_enc(1'b1, 1'b0, 20);
      set_enc(1'b1, 1'b1, 20);
      set_enc(1'b0, 1'b1, 20);
      set_enc(1'b0, 1'b0, 20);
    end
    chk("rev_en_count", n_en - b_en, 2);
    chk("rev_down_count", n_en_dn - b_dn, 2);
    chk("rev_err_count", n_err - b_err, 0);
    chk("rev_down_hold", 32'(bus.down), 1);

    // 3-cycle glitches on A never pass the filter
    b_en = n_en; b_err = n_err;
    for (int g = 0; g < 5; g++) begin
      set_enc(1'b1, 1'b0, 3);
      set_enc(1'b0, 1'b0, 3);
    end
    tick(20);
    chk("glitch_en_count", n_en - b_en, 0);
    chk("glitch_err_count", n_err - b_err, 0);

    // Rest at 11 through reset, then double-bit jumps
    drv_a = 1'b1; drv_b = 1'b1;
    rst = 1'b1;
    tick(3);
    b_err = n_err;
    rst = 1'b0;
    tick(12);
    chk("init11_err_count", n_err - b_err, 0);
    set_enc(1'b0, 1'b0, 20);
    chk("jump_err_count", n_err - b_err, 1);
    set_enc(1'b0, 1'b1, 20);
    set_enc(1'b1, 1'b1, 20);
    set_enc(1'b0, 1'b0, 20);
    chk("jump2_err_count", n_err - b_err, 2);
    b_en = n_en;
    set_enc(1'b0, 1'b1, 20);
    set_enc(1'b1, 1'b1, 20);
    chk("cleared_acc_no_en", n_en - b_en, 0);
    set_enc(1'b1, 1'b0, 20);
    set_enc(1'b0, 1'b0, 20);
    chk("cleared_acc_one_en", n_en - b_en, 1);

    // +1 +1 +1 -1 -1 then +1 x6
    b_en = n_en; b_dn = n_en_dn;
    set_enc(1'b0, 1'b1, 20);
    set_enc(1'b1, 1'b1, 20);
    set_enc(1'b1, 1'b0, 20);
    set_enc(1'b1, 1'b1, 20);
    set_enc(1'b0, 1'b1, 20);
    chk("reversal_no_en", n_en - b_en, 0);
    p = 1;
    for (int s = 0; s < 6; s++) begin
      p = (p + 1) % 4;
      nxt = gpair(p);
      set_enc(nxt[1], nxt[0], 20);
    end
    chk("six_up_en_count", n_en - b_en, 1);
    chk("six_up_down_count", n_en_dn - b_dn, 0);

    // Reset mid-detent discards three accumulated sub-steps
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(10);
    b_en = n_en; b_err = n_err;
    set_enc(1'b0, 1'b0, 20);
    set_enc(1'b0, 1'b1, 20);
    set_enc(1'b1, 1'b1, 20);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(10);
    set_enc(1'b1, 1'b0, 20);
    chk("midrst_en_count", n_en - b_en, 0);
    chk("midrst_err_count", n_err - b_err, 0);

    // Random walk with glitches, double jumps and occasional resets
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        rst = 1'b1;
        tick($urandom_range(1, 2));
        rst = 1'b0;
      end else if (r < 72) begin
        p = (gpos({drv_a, drv_b}) + (($urandom_range(0, 1) == 1) ? 1 : 3)) % 4;
        nxt = gpair(p);
        drv_a = nxt[1];
        drv_b = nxt[0];
      end else if (r < 82) begin
        drv_a = ~drv_a;
        drv_b = ~drv_b;
      end else begin
        if ($urandom_range(0, 1) == 1) drv_a = ~drv_a; else drv_b = ~drv_b;
        tick($urandom_range(1, 3));
        if ($urandom_range(0, 1) == 1) drv_a = ~drv_a; else drv_b = ~drv_b;
      end
      tick($urandom_range(1, 12));
    end
    tick(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
